// File: rtl/my_sync_pkg.sv
// ---------------------------------------------------------------------------
// my_sync_pkg
// Shared types and default widths for the sync-wave controller.
//   CNT_W_DEF   : default half-period counter width
//   BURST_W_DEF : default burst length / period counter width
//   sync_state_e: controller FSM states
// ---------------------------------------------------------------------------
package my_sync_pkg;

  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned BURST_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sync_state_e;

endpackage

// File: rtl/my_sync_halfper_cnt.sv
// ---------------------------------------------------------------------------
// my_sync_halfper_cnt
// Loadable half-period counter: counts 0..period-1 while enabled and raises
// o_term during the last count, wrapping to 0 on the following edge.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : force count to 0 (wins over enable)
//   i_enable       : advance the count
//   i_period       : half-period length in clocks
//   o_term         : terminal-count pulse (combinational, count == period-1)
// ---------------------------------------------------------------------------
module my_sync_halfper_cnt
  import my_sync_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_term
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_term = i_enable && (cnt_q == (i_period - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)       cnt_d = '0;
    else if (i_enable) cnt_d = o_term ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/my_sync_ctrl.sv
// ---------------------------------------------------------------------------
// my_sync_ctrl
// Square-wave sync generator with shadowed configuration, burst mode and a
// graceful stop. Config updates land only on falling toggles so the output
// never shows a partial half-period.
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_cfg_valid/o_cfg_ready: config handshake into the shadow register
//   i_cfg_period           : half-period in clocks (0 = off)
//   i_cfg_burst            : full periods per run (0 = continuous)
//   i_start, i_stop        : run control pulses
//   o_sync, o_sync_edge    : sync wave and toggle strobe
//   o_busy, o_done         : RUN/DRAIN indicator, burst-complete pulse
//   o_period_cnt           : completed full periods in the current run
// ---------------------------------------------------------------------------
module my_sync_ctrl
  import my_sync_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [CNT_W-1:0]   i_cfg_period,
  input  logic [BURST_W-1:0] i_cfg_burst,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_sync,
  output logic               o_sync_edge,
  output logic               o_busy,
  output logic               o_done,
  output logic [BURST_W-1:0] o_period_cnt
);

  sync_state_e state_q, state_d;

  logic               shd_empty_q, shd_empty_d;
  logic [CNT_W-1:0]   shd_per_q, shd_per_d, act_per_q, act_per_d;
  logic [BURST_W-1:0] shd_bst_q, shd_bst_d, act_bst_q, act_bst_d;
  logic               sync_q, sync_d, edge_q, edge_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;

  logic running, tc, fall, burst_hit, accept, apply, start_ok;

  assign running = (state_q != ST_IDLE);

  my_sync_halfper_cnt #(.CNT_W(CNT_W)) u_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (!running),
    .i_enable (running),
    .i_period (act_per_q),
    .o_term   (tc)
  );

  assign fall      = tc && sync_q;
  // Burst length is judged against the config in force during this period.
  assign burst_hit = fall && (act_bst_q != '0) &&
                     ((pcnt_q + BURST_W'(1)) == act_bst_q);
  assign accept    = i_cfg_valid && shd_empty_q;
  // Shadow moves to active immediately when idle, else only on a falling
  // toggle so the new half-period starts on a clean boundary.
  assign apply     = !shd_empty_q && (!running || fall);
  assign start_ok  = i_start && !i_stop && (act_per_q != '0);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN: begin
        if (fall) begin
          // A stop landing on a falling edge ends the run right here.
          if (burst_hit || i_stop || (apply && shd_per_q == '0))
            state_d = ST_IDLE;
        end else if (i_stop) begin
          state_d = sync_q ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: if (fall) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    sync_d = (state_d == ST_IDLE) ? 1'b0 : (tc ? ~sync_q : sync_q);
    edge_d = sync_d ^ sync_q;
    done_d = (state_q == ST_RUN) && burst_hit;
    busy_d = (state_d != ST_IDLE);
    pcnt_d = pcnt_q;
    if (state_q == ST_IDLE && state_d == ST_RUN) pcnt_d = '0;
    else if (fall)                                pcnt_d = pcnt_q + BURST_W'(1);

    shd_empty_d = shd_empty_q;
    shd_per_d   = shd_per_q;
    shd_bst_d   = shd_bst_q;
    act_per_d   = act_per_q;
    act_bst_d   = act_bst_q;
    // accept needs an empty shadow and apply a full one: never both.
    if (accept) begin
      shd_empty_d = 1'b0;
      shd_per_d   = i_cfg_period;
      shd_bst_d   = i_cfg_burst;
    end
    if (apply) begin
      shd_empty_d = 1'b1;
      act_per_d   = shd_per_q;
      act_bst_d   = shd_bst_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shd_empty_q <= 1'b1;
      shd_per_q   <= '0;
      shd_bst_q   <= '0;
      act_per_q   <= '0;
      act_bst_q   <= '0;
      sync_q      <= 1'b0;
      edge_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pcnt_q      <= '0;
    end else begin
      shd_empty_q <= shd_empty_d;
      shd_per_q   <= shd_per_d;
      shd_bst_q   <= shd_bst_d;
      act_per_q   <= act_per_d;
      act_bst_q   <= act_bst_d;
      sync_q      <= sync_d;
      edge_q      <= edge_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pcnt_q      <= pcnt_d;
    end
  end

  assign o_cfg_ready  = shd_empty_q;
  assign o_sync       = sync_q;
  assign o_sync_edge  = edge_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_period_cnt = pcnt_q;

endmodule

// File: tb/tb_my_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_my_sync_ctrl
// Directed bench for my_sync_ctrl. Cycle k is the interval after the k-th
// rising edge; "t0" is the cycle in which i_start is held high.
// ---------------------------------------------------------------------------
module tb_my_sync_ctrl;

  localparam int CW = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid, cfg_ready;
  logic [CW-1:0] cfg_period;
  logic [BW-1:0] cfg_burst;
  logic          start, stop;
  logic          sync, sync_edge, busy, done;
  logic [BW-1:0] pcnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0;

  always #5 clk = ~clk;

  my_sync_ctrl #(.CNT_W(CW), .BURST_W(BW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_period (cfg_period),
    .i_cfg_burst  (cfg_burst),
    .i_start      (start),
    .i_stop       (stop),
    .o_sync       (sync),
    .o_sync_edge  (sync_edge),
    .o_busy       (busy),
    .o_done       (done),
    .o_period_cnt (pcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int p, input int b);
    cfg_period = CW'(p);
    cfg_burst  = BW'(b);
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic do_start();
    t0    = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_burst = '0;
    start = 1'b0; stop = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_sync",  sync, 0);
    chk("rst_edge",  sync_edge, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_pcnt",  pcnt, 0);
    chk("rst_ready", cfg_ready, 1);
    rst_n = 1'b1;
    tick();

    // Start with the reset period of 0 is ignored
    do_start();
    chk("p0_start_busy", busy, 0);

    // P=4, B=2: rise t0+5, falls t0+9 and t0+17 (done)
    cfg(4, 2);
    chk("cfg_ready_low", cfg_ready, 0);
    tick();
    chk("cfg_ready_back", cfg_ready, 1);
    do_start();
    chk("b2_busy", busy, 1);
    chk("b2_sync_init", sync, 0);
    goto(t0+4);  chk("b2_sync_t4", sync, 0);
    goto(t0+5);  chk("b2_rise", sync, 1);  chk("b2_rise_edge", sync_edge, 1);
    goto(t0+6);  chk("b2_edge_pulse", sync_edge, 0);
    goto(t0+9);  chk("b2_fall1", sync, 0); chk("b2_pcnt1", pcnt, 1); chk("b2_nodone1", done, 0);
    goto(t0+13); chk("b2_rise2", sync, 1);
    goto(t0+17); chk("b2_fall2", sync, 0); chk("b2_done", done, 1);
                 chk("b2_pcnt2", pcnt, 2); chk("b2_idle", busy, 0);
    goto(t0+18); chk("b2_done_pulse", done, 0); chk("b2_pcnt_hold", pcnt, 2);

    // P=3 continuous, switch to P=5 during a high phase
    cfg(3, 0); tick();
    do_start();
    goto(t0+11);
    chk("sw_high", sync, 1);
    chk("sw_ready_pre", cfg_ready, 1);
    cfg(5, 0);
    chk("sw_ready_pend", cfg_ready, 0);
    chk("sw_still_high", sync, 1);
    goto(t0+13); chk("sw_fall", sync, 0); chk("sw_ready_free", cfg_ready, 1); chk("sw_pcnt", pcnt, 2);
    goto(t0+17); chk("sw_low_long", sync, 0);
    goto(t0+18); chk("sw_rise5", sync, 1); chk("sw_rise5_edge", sync_edge, 1);
    goto(t0+22); chk("sw_high_long", sync, 1);
    goto(t0+23); chk("sw_fall5", sync, 0);
    // Stop while low: idle after one cycle
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_low_busy", busy, 0);
    chk("stop_low_done", done, 0);
    chk("stop_low_pcnt", pcnt, 3);

    // Stop while high: drain to the next falling toggle
    do_start();
    goto(t0+7);  chk("drn_high", sync, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("drn_busy", busy, 1); chk("drn_sync", sync, 1);
    goto(t0+10); chk("drn_sync_hold", sync, 1);
    goto(t0+11); chk("drn_fall", sync, 0); chk("drn_idle", busy, 0); chk("drn_nodone", done, 0);

    // Start and stop together in idle
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("ss_idle", busy, 0);
    tick();
    chk("ss_idle2", busy, 0);

    // Stop on the final burst edge still reports done
    cfg(2, 1); tick();
    do_start();
    goto(t0+4); chk("bs_high", sync, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("bs_done", done, 1); chk("bs_idle", busy, 0);
    chk("bs_sync", sync, 0); chk("bs_pcnt", pcnt, 1);

    // Apply period 0 while running
    cfg(2, 0); tick();
    do_start();
    goto(t0+5); chk("z_low", sync, 0);
    cfg(0, 0);
    chk("z_pend", cfg_ready, 0);
    goto(t0+8); chk("z_high", sync, 1); chk("z_busy", busy, 1);
    goto(t0+9); chk("z_off", sync, 0); chk("z_idle", busy, 0);
                chk("z_nodone", done, 0); chk("z_ready", cfg_ready, 1);
    do_start();
    chk("z_restart_ign", busy, 0);

    // P=1 continuous: count wraps 15 -> 0 on the 16th fall
    cfg(1, 0); tick();
    do_start();
    goto(t0+31); chk("wr_pcnt15", pcnt, 15);
    goto(t0+33); chk("wr_pcnt0", pcnt, 0); chk("wr_low", sync, 0);
    goto(t0+34); chk("wr_high", sync, 1); chk("wr_busy", busy, 1);

    // Async reset while high
    rst_n = 1'b0;
    #1;
    chk("ar_sync",  sync, 0);
    chk("ar_busy",  busy, 0);
    chk("ar_pcnt",  pcnt, 0);
    chk("ar_edge",  sync_edge, 0);
    chk("ar_done",  done, 0);
    chk("ar_ready", cfg_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("ar_no_resume", busy, 0);
    chk("ar_sync_low",  sync, 0);
    do_start();
    chk("ar_start_p0", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
